// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, sequencer state encoding and default width for the calculator ALU
package calc_pkg;

    localparam int CALC_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ADDSUB = 3'd2,
        S_MUL    = 3'd3,
        S_DIV    = 3'd4,
        S_FIN    = 3'd5
    } state_e;

endpackage

// File: rtl/calc_shift_core.sv
// rtl/calc_shift_core.sv - iterative datapath: shift-add multiply and restoring shift-subtract divide
module calc_shift_core
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last_iter,
    output logic               zero_mplier,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int CW = $clog2(WIDTH);

    // mul: acc = partial product, sh = left-shifting multiplicand, mp = right-shifting multiplier
    // div: acc[WIDTH-1:0] = partial remainder, sh[WIDTH-1:0] = dividend/quotient, mp = divisor
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] sh;
    logic [WIDTH-1:0]   mp;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     trial;
    logic               fits;
    logic [WIDTH-1:0]   diff;

    // Outputs are the values this step produces, so the sequencer can latch them on the last step
    always_comb begin
        product   = acc + (mp[0] ? sh : '0);
        trial     = {acc[WIDTH-1:0], sh[WIDTH-1]};
        fits      = (trial >= {1'b0, mp});
        diff      = trial[WIDTH-1:0] - mp;
        quotient  = {sh[WIDTH-2:0], fits};
        remainder = fits ? diff : trial[WIDTH-1:0];
    end

    assign last_iter   = (cnt == CW'(WIDTH - 1));
    assign zero_mplier = (mp[WIDTH-1:1] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            sh  <= '0;
            mp  <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            sh  <= {{WIDTH{1'b0}}, a};
            mp  <= b;
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
            if (mode) begin
                acc <= {{WIDTH{1'b0}}, remainder};
                sh  <= {{WIDTH{1'b0}}, quotient};
            end else begin
                acc <= product;
                sh  <= {sh[2*WIDTH-2:0], 1'b0};
                mp  <= {1'b0, mp[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/calc_alu_sequencer.sv
// rtl/calc_alu_sequencer.sv - multi-cycle add/sub/mul/div sequencer with Busy/Done handshake
// Build option CALC_EARLY_TERM_EN: multiply stops once the remaining multiplier is zero.
module calc_alu_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH:0]   C,
    output logic [WIDTH-1:0] Rem,
    output logic             Err
);

`ifdef CALC_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic               core_load;
    logic               core_step;
    logic               core_div;
    logic               last_iter;
    logic               zero_mplier;
    logic               mul_last;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    assign core_load = (state == S_LOAD);
    assign core_step = (state == S_MUL) || (state == S_DIV);
    assign core_div  = (state == S_DIV);
    assign mul_last  = last_iter || (EARLY_TERM && zero_mplier);

    calc_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (Clk),
        .rst        (Reset),
        .load       (core_load),
        .step       (core_step),
        .mode       (core_div),
        .a          (a_q),
        .b          (b_q),
        .last_iter  (last_iter),
        .zero_mplier(zero_mplier),
        .product    (product),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    // Results are latched on the edge that enters the Done cycle, so Done and C/Rem/Err align
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            op_q  <= OP_ADD;
            a_q   <= '0;
            b_q   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            C     <= '0;
            Rem   <= '0;
            Err   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        op_q  <= op_e'(Op);
                        a_q   <= A;
                        b_q   <= B;
                        Busy  <= 1'b1;
                        C     <= '0;
                        Rem   <= '0;
                        Err   <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    case (op_q)
                        OP_ADD: begin
                            C     <= {1'b0, a_q} + {1'b0, b_q};
                            Done  <= 1'b1;
                            state <= S_ADDSUB;
                        end
                        OP_SUB: begin
                            C     <= {1'b0, a_q} - {1'b0, b_q};
                            Done  <= 1'b1;
                            state <= S_ADDSUB;
                        end
                        OP_MUL: begin
                            state <= S_MUL;
                        end
                        default: begin
                            if (b_q == '0) begin
                                C     <= '1;
                                Err   <= 1'b1;
                                Done  <= 1'b1;
                                state <= S_FIN;
                            end else begin
                                state <= S_DIV;
                            end
                        end
                    endcase
                end
                // The single add/sub step already landed in this state's Done cycle
                S_ADDSUB: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_MUL: begin
                    if (mul_last) begin
                        C     <= product[WIDTH:0];
                        Err   <= |product[2*WIDTH-1:WIDTH+1];
                        Done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_DIV: begin
                    if (last_iter) begin
                        C     <= {1'b0, quotient};
                        Rem   <= remainder;
                        Done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// tb/tb_calc_alu_sequencer.sv - directed and random checks of calc_alu_sequencer against an arithmetic model
module tb_calc_alu_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [15:0] A;
    logic [15:0] B;
    logic        Busy;
    logic        Done;
    logic [16:0] C;
    logic [15:0] Rem;
    logic        Err;

    int checks   = 0;
    int failures = 0;

    calc_alu_sequencer #(.WIDTH(16)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .Op   (Op),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .Done (Done),
        .C    (C),
        .Rem  (Rem),
        .Err  (Err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mul_latency(input logic [15:0] b);
`ifdef CALC_EARLY_TERM_EN
        int n = 1;
        for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
        return 2 + n;
`else
        return 18;
`endif
    endfunction

    // Issue one op in cycle 0, optionally pulse Start again in cycles p1/p2, and check the result
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int p1, input int p2);
        logic [16:0] ec;
        logic [15:0] er;
        logic        ee;
        longint      p;
        int          lat;
        int          done_at;
        int          ndone;
        er = '0;
        ee = 1'b0;
        case (op)
            2'b00: begin ec = {1'b0, a} + {1'b0, b}; lat = 2; end
            2'b01: begin ec = {1'b0, a} - {1'b0, b}; lat = 2; end
            2'b10: begin
                p   = longint'(a) * longint'(b);
                ec  = p[16:0];
                ee  = ((p >> 17) != 0);
                lat = mul_latency(b);
            end
            default: begin
                if (b == 0) begin ec = 17'h1FFFF; ee = 1'b1; lat = 2; end
                else begin ec = 17'(a / b); er = a % b; lat = 18; end
            end
        endcase

        @(posedge Clk); #1;
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 2'($urandom); A = 16'($urandom); B = 16'($urandom);
        done_at = -1;
        ndone   = 0;
        for (int k = 1; k <= 40; k++) begin
            if (Done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = k;
                    check_eq("result_c", 32'(C), 32'(ec));
                    check_eq("result_rem", 32'(Rem), 32'(er));
                    check_eq("result_err", 32'(Err), 32'(ee));
                end
            end
            if (done_at < 0 || k == done_at) begin
                check_eq("busy_in_flight", 32'(Busy), 32'd1);
            end else begin
                check_eq("busy_after_done", 32'(Busy), 32'd0);
                check_eq("hold_c", 32'(C), 32'(ec));
                break;
            end
            Start = (k == p1 || k == p2);
            if (Start) begin
                Op = 2'($urandom); A = 16'($urandom); B = 16'($urandom);
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
        check_eq("done_cycle", 32'(done_at), 32'(lat));
        check_eq("done_count", 32'(ndone), 32'd1);
    endtask

    initial begin
        int ndone;
        logic [1:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;

        Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_done", 32'(Done), 32'd0);
        check_eq("rst_c", 32'(C), 32'd0);
        check_eq("rst_rem", 32'(Rem), 32'd0);
        check_eq("rst_err", 32'(Err), 32'd0);
        Reset = 1'b0;

        run_op(2'b00, 16'hFFFF, 16'h0001, -1, -1);
        run_op(2'b01, 16'h0003, 16'h0005, -1, -1);
        run_op(2'b10, 16'h00FF, 16'h0101, -1, -1);
        run_op(2'b10, 16'hFFFF, 16'h0002, -1, -1);
        run_op(2'b10, 16'h0200, 16'h0200, -1, -1);
        run_op(2'b10, 16'h1234, 16'h0000, -1, -1);
        run_op(2'b10, 16'hABCD, 16'h0001, -1, -1);
        run_op(2'b11, 16'd1000, 16'd7, -1, -1);
        run_op(2'b11, 16'h4321, 16'h0000, -1, -1);
        run_op(2'b11, 16'hFFFF, 16'hFFFF, -1, -1);
        // Top multiplier bit set keeps the latency at 18 in both builds
        run_op(2'b10, 16'h7777, 16'h8001, 5, 18);

        // Reset in cycle 9 of a divide
        @(posedge Clk); #1;
        Start = 1'b1; Op = 2'b11; A = 16'd1000; B = 16'd7;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        check_eq("busy_before_reset", 32'(Busy), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check_eq("abort_busy", 32'(Busy), 32'd0);
        check_eq("abort_done", 32'(Done), 32'd0);
        check_eq("abort_c", 32'(C), 32'd0);
        check_eq("abort_rem", 32'(Rem), 32'd0);
        check_eq("abort_err", 32'(Err), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge Clk); #1;
            if (Done) ndone++;
        end
        check_eq("abort_no_done", 32'(ndone), 32'd0);
        run_op(2'b00, 16'h1234, 16'h4321, -1, -1);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(0, 255));
                default: rb = 16'($urandom);
            endcase
            run_op(rop, ra, rb, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
